// File: rtl/sysid_verifier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysid_verifier_pkg
// Brief    : Shared types and constants for the system-ID verifier.
// Revision : 1.0 - initial release
// ============================================================================
package sysid_verifier_pkg;

    localparam logic [31:0] c_default_expected_id = 32'hAAAAAAAA;
    localparam logic [31:0] c_default_expected_ts = 32'h53699D78;
    localparam int          c_timer_w             = 16;
    localparam int          c_retry_w             = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sysid_read_timer.sv
`default_nettype none
// ============================================================================
// Module   : sysid_read_timer
// Brief    : Per-read stall counter with clear, enable and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_read_timer
    import sysid_verifier_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [c_timer_w-1:0] c_tc_value = c_timer_w'(LIMIT - 1);

    logic [c_timer_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_timer_w'(1);
        end
    end

    // Fires on the LIMIT-th stalled cycle, so the read gives up right after it.
    assign o_tc = i_en && (r_count == c_tc_value);

endmodule
`default_nettype wire

// File: rtl/sysid_verifier.sv
`default_nettype none
// ============================================================================
// Module   : sysid_verifier
// Brief    : Reads ID/timestamp over Avalon-MM, compares, retries on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_verifier
    import sysid_verifier_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = c_default_expected_id,
    parameter logic [31:0] EXPECTED_TS = c_default_expected_ts,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retries_used
);

    localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_rd_active;
    logic                 w_rd_done;
    logic                 w_stall;
    logic                 w_timer_tc;
    logic                 w_words_ok;
    logic                 w_can_retry;
    logic [c_retry_w-1:0] r_retry_cnt;
    logic                 r_match;
    logic                 r_timeout_err;
    logic [31:0]          r_id_value;
    logic [31:0]          r_ts_value;
    logic [c_retry_w-1:0] r_retries_used;

    assign w_rd_active = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_rd_done   = w_rd_active && !avm_waitrequest;
    assign w_stall     = w_rd_active && avm_waitrequest;
    assign w_words_ok  = (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
    assign w_can_retry = (r_retry_cnt < c_max_retry);

    // Cleared whenever no read is pending or one completes, so each read starts at zero.
    sysid_read_timer #(
        .LIMIT (TIMEOUT)
    ) u_read_timer (
        .clk   (clock),
        .rst   (reset),
        .i_clr (!w_rd_active || w_rd_done),
        .i_en  (w_stall),
        .o_tc  (w_timer_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RD_ID;
                end
            end
            RD_ID: begin
                busy     = 1'b1;
                avm_read = 1'b1;
                if (w_timer_tc) begin
                    w_state_nxt = FIN;
                end else if (!avm_waitrequest) begin
                    w_state_nxt = RD_TS;
                end
            end
            RD_TS: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (w_timer_tc) begin
                    w_state_nxt = FIN;
                end else if (!avm_waitrequest) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (!w_words_ok && w_can_retry) begin
                    w_state_nxt = RD_ID;
                end else begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result registers are loaded on the transition into FIN so they are valid alongside done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retry_cnt    <= '0;
            r_match        <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_id_value     <= '0;
            r_ts_value     <= '0;
            r_retries_used <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_retry_cnt   <= '0;
                        r_match       <= 1'b0;
                        r_timeout_err <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (w_timer_tc) begin
                        r_timeout_err  <= 1'b1;
                        r_match        <= 1'b0;
                        r_retries_used <= r_retry_cnt;
                    end else if (w_rd_done) begin
                        if (r_state == RD_ID) begin
                            r_id_value <= avm_readdata;
                        end else begin
                            r_ts_value <= avm_readdata;
                        end
                    end
                end
                CHECK: begin
                    if (w_words_ok) begin
                        r_match        <= 1'b1;
                        r_retries_used <= r_retry_cnt;
                    end else if (w_can_retry) begin
                        r_retry_cnt <= r_retry_cnt + c_retry_w'(1);
                    end else begin
                        r_match        <= 1'b0;
                        r_retries_used <= r_retry_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign match        = r_match;
    assign timeout_err  = r_timeout_err;
    assign id_value     = r_id_value;
    assign ts_value     = r_ts_value;
    assign retries_used = r_retries_used;

endmodule
`default_nettype wire
